// File: rtl/mem_wb_pipe_pkg.sv
// mem_wb_pipe_pkg: default widths, lane layout, constants and occupancy encoding shared by the MEM->WB stage.
package mem_wb_pipe_pkg;
    localparam int DEF_ISSUE_WIDTH    = 2;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_PC_WIDTH       = 32;
    localparam int DEF_INST_WIDTH     = 32;
    localparam logic [DEF_REG_ADDR_WIDTH-1:0] NOP_REG_ADDR = '0;
    localparam logic [DEF_DATA_WIDTH-1:0]     ZERO_WORD    = '0;
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ONE    = 2'd1;
    localparam logic [1:0] ST_TWO    = 2'd2;
    localparam logic [1:0] RST_STATE = ST_EMPTY;
    typedef struct packed {
        logic [DEF_REG_ADDR_WIDTH-1:0] wd;
        logic                          wreg;
        logic [DEF_DATA_WIDTH-1:0]     wdata;
        logic                          llbit_we;
        logic                          llbit_value;
        logic [DEF_PC_WIDTH-1:0]       pc;
        logic [DEF_INST_WIDTH-1:0]     instr;
    } lane_t;
endpackage

// File: rtl/mem_wb_pipe_slot.sv
// mem_wb_pipe_slot: one bundle register with per-lane valid; lanes captured as invalid are stored as all-zero.
module mem_wb_pipe_slot #(
    parameter int LANES  = 2,
    parameter int LANE_W = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [LANES-1:0]        i_valid,
    input  logic [LANES*LANE_W-1:0] i_data,
    output logic [LANES-1:0]        o_valid,
    output logic [LANES*LANE_W-1:0] o_data
);
    logic [LANES-1:0]        r_valid;
    logic [LANES*LANE_W-1:0] r_data;
    logic [LANES*LANE_W-1:0] w_masked;
    for (genvar i = 0; i < LANES; i++) begin : g_mask
        assign w_masked[i*LANE_W +: LANE_W] = i_valid[i] ? i_data[i*LANE_W +: LANE_W] : '0;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_data  <= w_masked;
        end
    end
    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB register with a one-entry skid buffer; write and commit strobes fire once per instruction.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int ISSUE_WIDTH    = DEF_ISSUE_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int INST_WIDTH     = DEF_INST_WIDTH
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_flush,
    input  logic [ISSUE_WIDTH-1:0]             i_mem_valid,
    output logic                               o_mem_ready,
    input  logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] i_mem_wd,
    input  logic [ISSUE_WIDTH-1:0]             i_mem_wreg,
    input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  i_mem_wdata,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]    i_mem_inst_pc,
    input  logic [ISSUE_WIDTH*INST_WIDTH-1:0]  i_mem_instr,
    input  logic [ISSUE_WIDTH-1:0]             i_mem_llbit_we,
    input  logic [ISSUE_WIDTH-1:0]             i_mem_llbit_value,
    input  logic                               i_wb_ready,
    output logic                               o_wb_valid,
    output logic [ISSUE_WIDTH*REG_ADDR_WIDTH-1:0] o_wb_wd,
    output logic [ISSUE_WIDTH-1:0]             o_wb_wreg,
    output logic [ISSUE_WIDTH*DATA_WIDTH-1:0]  o_wb_wdata,
    output logic [ISSUE_WIDTH-1:0]             o_wb_llbit_we,
    output logic [ISSUE_WIDTH-1:0]             o_wb_llbit_value,
    output logic [ISSUE_WIDTH-1:0]             o_debug_commit_valid,
    output logic [ISSUE_WIDTH*PC_WIDTH-1:0]    o_debug_commit_pc,
    output logic [ISSUE_WIDTH*INST_WIDTH-1:0]  o_debug_commit_instr
);
    localparam int LANE_W  = REG_ADDR_WIDTH + DATA_WIDTH + PC_WIDTH + INST_WIDTH + 3;
    localparam int O_PC    = INST_WIDTH;
    localparam int O_LLV   = INST_WIDTH + PC_WIDTH;
    localparam int O_LLE   = O_LLV + 1;
    localparam int O_WDATA = O_LLV + 2;
    localparam int O_WREG  = O_WDATA + DATA_WIDTH;
    localparam int O_WD    = O_WREG + 1;
    logic [1:0]                    r_state;
    logic [1:0]                    w_state_nxt;
    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          w_h_load;
    logic                          w_h_clear;
    logic                          w_s_load;
    logic                          w_s_clear;
    logic [ISSUE_WIDTH-1:0]        w_h_vld;
    logic [ISSUE_WIDTH-1:0]        w_s_vld;
    logic [ISSUE_WIDTH-1:0]        w_h_vld_in;
    logic [ISSUE_WIDTH-1:0]        w_commit;
    logic [ISSUE_WIDTH*LANE_W-1:0] w_in_data;
    logic [ISSUE_WIDTH*LANE_W-1:0] w_h_data;
    logic [ISSUE_WIDTH*LANE_W-1:0] w_s_data;
    logic [ISSUE_WIDTH*LANE_W-1:0] w_h_data_in;
    // Handshake decodes come only from the state register, so ready never depends on wb_ready.
    assign o_mem_ready = (r_state != ST_TWO);
    assign o_wb_valid  = (r_state != ST_EMPTY);
    assign w_in_fire   = (|i_mem_valid) & o_mem_ready;
    assign w_out_fire  = o_wb_valid & i_wb_ready;
    assign w_commit    = {ISSUE_WIDTH{w_out_fire}} & w_h_vld;
    always_comb begin
        w_h_load    = ~i_flush & ((r_state == ST_TWO) ? w_out_fire : (w_in_fire & ((r_state == ST_EMPTY) | w_out_fire)));
        w_h_clear   = i_flush | ((r_state == ST_ONE) & w_out_fire & ~w_in_fire);
        w_s_load    = ~i_flush & (r_state == ST_ONE) & w_in_fire & ~w_out_fire;
        w_s_clear   = i_flush | ((r_state == ST_TWO) & w_out_fire);
        w_h_vld_in  = (r_state == ST_TWO) ? w_s_vld : i_mem_valid;
        w_h_data_in = (r_state == ST_TWO) ? w_s_data : w_in_data;
        w_state_nxt = i_flush ? ST_EMPTY :
                      (r_state == ST_EMPTY) ? (w_in_fire ? ST_ONE : ST_EMPTY) :
                      (r_state == ST_ONE) ? ((w_in_fire & ~w_out_fire) ? ST_TWO :
                                             (~w_in_fire & w_out_fire) ? ST_EMPTY : ST_ONE) :
                      (w_out_fire ? ST_ONE : ST_TWO);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RST_STATE;
        else          r_state <= w_state_nxt;
    end
    mem_wb_pipe_slot #(.LANES(ISSUE_WIDTH), .LANE_W(LANE_W)) u_head (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_h_clear),
        .i_load  (w_h_load),
        .i_valid (w_h_vld_in),
        .i_data  (w_h_data_in),
        .o_valid (w_h_vld),
        .o_data  (w_h_data)
    );
    mem_wb_pipe_slot #(.LANES(ISSUE_WIDTH), .LANE_W(LANE_W)) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (w_s_clear),
        .i_load  (w_s_load),
        .i_valid (i_mem_valid),
        .i_data  (w_in_data),
        .o_valid (w_s_vld),
        .o_data  (w_s_data)
    );
    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_lane
        logic [LANE_W-1:0] w_h_lane;
        assign w_in_data[i*LANE_W +: LANE_W] = {i_mem_wd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH], i_mem_wreg[i],
                                                i_mem_wdata[i*DATA_WIDTH +: DATA_WIDTH], i_mem_llbit_we[i],
                                                i_mem_llbit_value[i], i_mem_inst_pc[i*PC_WIDTH +: PC_WIDTH],
                                                i_mem_instr[i*INST_WIDTH +: INST_WIDTH]};
        assign w_h_lane = w_h_data[i*LANE_W +: LANE_W];
        assign o_wb_wd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = w_h_lane[O_WD +: REG_ADDR_WIDTH];
        assign o_wb_wdata[i*DATA_WIDTH +: DATA_WIDTH]      = w_h_lane[O_WDATA +: DATA_WIDTH];
        assign o_wb_llbit_value[i]                         = w_h_lane[O_LLV];
        assign o_wb_wreg[i]                                = w_commit[i] & w_h_lane[O_WREG];
        assign o_wb_llbit_we[i]                            = w_commit[i] & w_h_lane[O_LLE];
        assign o_debug_commit_pc[i*PC_WIDTH +: PC_WIDTH]   = w_commit[i] ? w_h_lane[O_PC +: PC_WIDTH] : '0;
        assign o_debug_commit_instr[i*INST_WIDTH +: INST_WIDTH] = w_commit[i] ? w_h_lane[0 +: INST_WIDTH] : '0;
    end
    assign o_debug_commit_valid = w_commit;
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed and random traffic against a two-deep FIFO reference model of the MEM->WB stage.
module tb_mem_wb_pipe;
    typedef struct packed {
        logic        v;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        lle;
        logic        llv;
        logic [31:0] pc;
        logic [31:0] instr;
    } lane_m;
    typedef lane_m [1:0] bun_m;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        wb_ready = 0;
    logic [1:0]  mem_valid = 0;
    logic [1:0]  wreg = 0;
    logic [1:0]  lle = 0;
    logic [1:0]  llv = 0;
    logic [9:0]  wd = 0;
    logic [63:0] wdata = 0;
    logic [63:0] pc = 0;
    logic [63:0] instr = 0;
    logic        o_mem_ready;
    logic        o_wb_valid;
    logic [9:0]  o_wb_wd;
    logic [1:0]  o_wb_wreg;
    logic [63:0] o_wb_wdata;
    logic [1:0]  o_wb_llbit_we;
    logic [1:0]  o_wb_llbit_value;
    logic [1:0]  o_commit_valid;
    logic [63:0] o_commit_pc;
    logic [63:0] o_commit_instr;
    bun_m        q[$];
    int          checks = 0;
    int          errors = 0;
    always #5 clk = ~clk;
    mem_wb_pipe dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_flush              (flush),
        .i_mem_valid          (mem_valid),
        .o_mem_ready          (o_mem_ready),
        .i_mem_wd             (wd),
        .i_mem_wreg           (wreg),
        .i_mem_wdata          (wdata),
        .i_mem_inst_pc        (pc),
        .i_mem_instr          (instr),
        .i_mem_llbit_we       (lle),
        .i_mem_llbit_value    (llv),
        .i_wb_ready           (wb_ready),
        .o_wb_valid           (o_wb_valid),
        .o_wb_wd              (o_wb_wd),
        .o_wb_wreg            (o_wb_wreg),
        .o_wb_wdata           (o_wb_wdata),
        .o_wb_llbit_we        (o_wb_llbit_we),
        .o_wb_llbit_value     (o_wb_llbit_value),
        .o_debug_commit_valid (o_commit_valid),
        .o_debug_commit_pc    (o_commit_pc),
        .o_debug_commit_instr (o_commit_instr)
    );
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask
    task automatic offer(input logic [1:0] v, input logic [31:0] p0, input logic [4:0] d0, input logic [4:0] d1,
                         input logic [31:0] x0, input logic [31:0] x1, input logic [1:0] we,
                         input logic [1:0] ll_we, input logic [1:0] ll_v);
        mem_valid = v;
        pc        = {p0 + 32'd4, p0};
        instr     = {~p0, p0 ^ 32'h0280_0000};
        wd        = {d1, d0};
        wdata     = {x1, x0};
        wreg      = we;
        lle       = ll_we;
        llv       = ll_v;
    endtask
    task automatic offer_random();
        mem_valid = 2'($urandom_range(0, 3));
        pc        = {$urandom, $urandom};
        instr     = {$urandom, $urandom};
        wd        = 10'($urandom);
        wdata     = {$urandom, $urandom};
        wreg      = 2'($urandom);
        lle       = 2'($urandom);
        llv       = 2'($urandom);
    endtask
    function automatic bun_m capture();
        bun_m b;
        for (int i = 0; i < 2; i++) begin
            b[i] = '0;
            if (mem_valid[i]) b[i] = '{1'b1, wd[i*5 +: 5], wreg[i], wdata[i*32 +: 32], lle[i], llv[i],
                                       pc[i*32 +: 32], instr[i*32 +: 32]};
        end
        return b;
    endfunction
    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input string tag);
        bun_m        h;
        bun_m        dropped;
        logic        hv;
        logic        of;
        logic        inf;
        logic [1:0]  cv;
        logic [1:0]  ewreg;
        logic [1:0]  elle;
        logic [63:0] epc;
        logic [63:0] ein;
        hv  = q.size() > 0;
        h   = hv ? q[0] : '0;
        of  = hv & wb_ready;
        inf = (|mem_valid) & (q.size() < 2);
        for (int i = 0; i < 2; i++) begin
            cv[i]            = of & h[i].v;
            ewreg[i]         = cv[i] & h[i].wreg;
            elle[i]          = cv[i] & h[i].lle;
            epc[i*32 +: 32]  = cv[i] ? h[i].pc : 32'd0;
            ein[i*32 +: 32]  = cv[i] ? h[i].instr : 32'd0;
        end
        #1;
        chk({tag, ".mem_ready"}, o_mem_ready, q.size() < 2);
        chk({tag, ".wb_valid"}, o_wb_valid, hv);
        chk({tag, ".wb_wreg"}, o_wb_wreg, ewreg);
        chk({tag, ".wb_llbit_we"}, o_wb_llbit_we, elle);
        chk({tag, ".commit_valid"}, o_commit_valid, cv);
        chk({tag, ".commit_pc"}, o_commit_pc, epc);
        chk({tag, ".commit_instr"}, o_commit_instr, ein);
        if (hv) begin
            chk({tag, ".wb_wd"}, o_wb_wd, {h[1].wd, h[0].wd});
            chk({tag, ".wb_wdata"}, o_wb_wdata, {h[1].wdata, h[0].wdata});
            chk({tag, ".wb_llbit_value"}, o_wb_llbit_value, {h[1].llv, h[0].llv});
        end
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (of) dropped = q.pop_front();
            if (inf) q.push_back(capture());
        end
        @(negedge clk);
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".mem_ready"}, o_mem_ready, 1'b1);
        chk({tag, ".wb_valid"}, o_wb_valid, 1'b0);
        chk({tag, ".wb_wreg"}, o_wb_wreg, 2'b00);
        chk({tag, ".wb_llbit_we"}, o_wb_llbit_we, 2'b00);
        chk({tag, ".wb_llbit_value"}, o_wb_llbit_value, 2'b00);
        chk({tag, ".commit_valid"}, o_commit_valid, 2'b00);
        chk({tag, ".commit_pc"}, o_commit_pc, 64'd0);
        chk({tag, ".commit_instr"}, o_commit_instr, 64'd0);
        chk({tag, ".wb_wd"}, o_wb_wd, 10'd0);
        chk({tag, ".wb_wdata"}, o_wb_wdata, 64'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1;
        wb_ready = 1;
        for (int k = 0; k < 6; k++) begin
            offer(2'b11, 32'h1c00_0000, 5'd3, 5'd4, 32'hAA + k, 32'hBB + k, 2'b11, 2'b00, 2'b00);
            cycle("stream");
        end
        offer(2'b00, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        cycle("stream_tail");
        cycle("idle");
        wb_ready = 0;
        for (int k = 0; k < 4; k++) begin
            offer(2'b11, 32'h1c00_0100 + 32'(k * 8), 5'd5 + 5'(k), 5'd9, 32'h100 + k, 32'h200 + k, 2'b11, 2'b00, 2'b00);
            cycle("bp_fill");
            if (k == 2) k = 3;
        end
        wb_ready = 1;
        cycle("bp_drain0");
        cycle("bp_drain1");
        offer(2'b00, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        repeat (2) cycle("bp_tail");
        offer(2'b01, 32'h1c00_0200, 5'd7, 5'd8, 32'h1234, 32'h5678, 2'b11, 2'b11, 2'b11);
        cycle("partial_in");
        offer(2'b00, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        cycle("partial_out");
        wb_ready = 0;
        offer(2'b11, 32'h1c00_0300, 5'd1, 5'd2, 32'h11, 32'h22, 2'b11, 2'b00, 2'b00);
        cycle("fl_fill0");
        offer(2'b11, 32'h1c00_0308, 5'd3, 5'd4, 32'h33, 32'h44, 2'b11, 2'b00, 2'b00);
        cycle("fl_fill1");
        offer(2'b11, 32'h1c00_0310, 5'd5, 5'd6, 32'h55, 32'h66, 2'b11, 2'b00, 2'b00);
        flush = 1;
        cycle("flush");
        flush = 0;
        wb_ready = 1;
        offer(2'b00, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        repeat (2) cycle("post_flush");
        wb_ready = 0;
        offer(2'b10, 32'h1c00_0400, 5'd0, 5'd12, 32'h0, 32'hCAFE, 2'b10, 2'b10, 2'b10);
        cycle("ll_in");
        offer(2'b00, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00);
        repeat (3) cycle("ll_hold");
        wb_ready = 1;
        cycle("ll_fire");
        cycle("ll_after");
        for (int k = 0; k < 400; k++) begin
            offer_random();
            wb_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            cycle("rnd");
        end
        flush = 0;
        wb_ready = 0;
        offer(2'b11, 32'h1c00_0500, 5'd1, 5'd2, 32'h77, 32'h88, 2'b11, 2'b11, 2'b11);
        cycle("rst_fill0");
        cycle("rst_fill1");
        cycle("rst_full");
        mem_valid = 2'b00;
        wb_ready = 1;
        rst_n = 0;
        #1;
        chk_reset_outputs("rst_mid");
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        cycle("rst_after");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
Name: mem_wb_pipe

Overview:
Parametrised MEM→WB pipeline register for the multi-issue core. It carries ISSUE_WIDTH lanes per bundle and replaces the global stall with a valid/ready handshake. A one-entry skid buffer lets mem_ready be driven from a register. Each lane's register-file write and its difftest commit pulse fire exactly once per instruction, including under back-pressure and flush.

Parameters:
ISSUE_WIDTH, 2, lanes per bundle; lane 0 is the oldest instruction.
DATA_WIDTH, 32, register write-data width.
REG_ADDR_WIDTH, 5, destination register index width.
PC_WIDTH, 32, instruction address width.
INST_WIDTH, 32, instruction word width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
flush  in  1  kill every bundle held in this stage (exception/ertn).
mem_valid  in  ISSUE_WIDTH  per-lane valid; the bundle is valid when any bit is set.
mem_ready  out  1  stage can accept a bundle this cycle.
mem_wd  in  ISSUE_WIDTH*REG_ADDR_WIDTH  per-lane destination register.
mem_wreg  in  ISSUE_WIDTH  per-lane write enable.
mem_wdata  in  ISSUE_WIDTH*DATA_WIDTH  per-lane write data.
mem_inst_pc  in  ISSUE_WIDTH*PC_WIDTH  per-lane PC.
mem_instr  in  ISSUE_WIDTH*INST_WIDTH  per-lane instruction word.
mem_llbit_we  in  ISSUE_WIDTH  per-lane LLbit write enable.
mem_llbit_value  in  ISSUE_WIDTH  per-lane LLbit value.
wb_ready  in  1  downstream accepts the head bundle this cycle.
wb_valid  out  1  head bundle present.
wb_wd  out  ISSUE_WIDTH*REG_ADDR_WIDTH  head per-lane destination.
wb_wreg  out  ISSUE_WIDTH  register-file write strobe, already qualified by fire.
wb_wdata  out  ISSUE_WIDTH*DATA_WIDTH  head per-lane data.
wb_llbit_we  out  ISSUE_WIDTH  LLbit write strobe, qualified by fire.
wb_llbit_value  out  ISSUE_WIDTH  LLbit value.
debug_commit_valid  out  ISSUE_WIDTH  one-cycle commit pulse per lane.
debug_commit_pc  out  ISSUE_WIDTH*PC_WIDTH  committed PC, zero when not committing.
debug_commit_instr  out  ISSUE_WIDTH*INST_WIDTH  committed instruction, zero when not committing.

Behaviour:
- Storage: head register H and skid register S, each holding a full bundle plus a per-lane valid vector.
- Occupancy states: EMPTY (no H, no S), ONE (H only), TWO (H and S).
- Reset: rst low asynchronously clears H, S and all valid bits; state = EMPTY. All outputs read 0, except mem_ready = 1.
- Handshake definitions:
  - in_fire = (|mem_valid) & mem_ready.
  - out_fire = wb_valid & wb_ready.
- mem_ready = ~S.valid. It is a pure register decode with no combinational path from wb_ready.
- wb_valid = H.valid.
- Capture rule: lanes with mem_valid[i] = 0 are stored with wd, wreg, wdata, llbit_we, pc and instr all zero.
- Transitions when flush = 0:
  - EMPTY: in_fire → load H, go to ONE.
  - ONE:
    - out_fire & in_fire → H ← input, stay in ONE.
    - out_fire only → EMPTY.
    - in_fire only → S ← input, go to TWO.
    - neither → hold.
  - TWO: out_fire → H ← S, clear S, go to ONE. No capture is possible because mem_ready = 0.
- Flush:
  - Synchronous; clears H and S valid bits and the held payload to zero; next state = EMPTY.
  - Dominates in_fire in the same cycle: the incoming bundle is dropped, and the producer must treat it as killed.
  - Flush does not gate out_fire in its own cycle: a head bundle that fires while flush is high still commits.
- Output qualification (combinational from H and wb_ready):
  - wb_wreg[i] = out_fire & H.wreg[i] & H.lane_valid[i].
  - wb_llbit_we[i] follows the same rule.
  - debug_commit_valid[i] = out_fire & H.lane_valid[i].
  - debug_commit_pc and debug_commit_instr are driven only when debug_commit_valid[i] is set, otherwise 0.
- wb_wd, wb_wdata and wb_llbit_value are raw head contents; they are meaningful only with their strobes.
- Ordering: bundles leave in arrival order. Lane order within a bundle is preserved, lane 0 first.
- Throughput: one bundle per cycle sustained when wb_ready = 1. Latency from in_fire to wb_valid is 1 cycle.
- Back-pressure: with wb_ready = 0, at most two bundles are buffered, then mem_ready drops.

Decomposition:
- Shared package/defines: the bundle struct layout (lane fields and widths), and the constants NOP_REG_ADDR, ZERO_WORD and the reset defaults.
- Sub-module pipe_slot: one bundle register with valid vector, load, clear and zero-on-invalid capture.
- mem_wb_pipe instantiates pipe_slot twice, for H and S, plus the occupancy FSM and the output qualification logic.

Test Plan:
- Reset mid-traffic: rst low while in TWO → all outputs 0 immediately, mem_ready = 1, state EMPTY after release.
- Streaming:
  - Stimulus: wb_ready = 1; bundles {pc 0x1c000000/0x1c000004, wd 3/4, wdata 0xAA/0xBB} every cycle.
  - Response: each appears one cycle later with wb_wreg = 2'b11 and debug_commit_valid = 2'b11 for exactly one cycle.
- Back-pressure:
  - Stimulus: wb_ready = 0, then three bundles offered.
  - Response: the first two are accepted, mem_ready = 0 on the third; no wb_wreg or commit pulses.
  - Then wb_ready = 1: the bundles drain in order over 2 cycles, and the third is accepted in the drain cycle.
- Partial bundle: mem_valid = 2'b01 with lane-1 fields nonzero → lane-1 outputs all zero, debug_commit_valid = 2'b01.
- Flush:
  - Stimulus: flush with H and S full and mem_valid = 2'b11 in the same cycle.
  - Response: next cycle wb_valid = 0, no commits, mem_ready = 1; the incoming bundle never appears.
- LLbit: lane 1 carries llbit_we = 1, value 1, under wb_ready = 0 for 3 cycles → wb_llbit_we pulses once, in the fire cycle only.
